cabac_byte_writer: RTL

CABAC_BYTE_WRITER -- requirements
Module: cabac_byte_writer

---
 rtl/cabac_pkg.sv | 25 ++
 rtl/cabac_byte_writer_if.sv | 27 ++
 rtl/cabac_out_reg.sv | 25 ++
 rtl/cabac_byte_writer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cabac_pkg.sv
// Shared types and constants for the CABAC byte writer: FSM states, lead byte
// layout, counter width default and the buffered-byte idle value.
package cabac_pkg;

    localparam int unsigned CNT_W_DEF        = 16;
    localparam logic [7:0]  BUF_INIT         = 8'hFF;
    localparam logic [8:0]  LEAD_OUTSTANDING = 9'h0FF;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_EMIT_FIRST = 2'd1,
        ST_EMIT_RUN   = 2'd2
    } state_t;

    typedef struct packed {
        logic       carry;
        logic [7:0] value;
    } lead_t;

    // 8-bit add of a carry bit; a carry into 0xFF wraps to 0x00.
    function automatic logic [7:0] add_carry(input logic [7:0] b, input logic c);
        return b + 8'(c);
    endfunction

endpackage

// File: rtl/cabac_byte_writer_if.sv
// Handshake bundle between the arithmetic encoder core, the byte writer and
// the downstream bitstream sink.
interface cabac_byte_writer_if;
    import cabac_pkg::*;

    logic       lead_valid;
    lead_t      lead_byte;
    logic       lead_ready;
    logic       flush_valid;
    logic       flush_carry;
    logic       flush_ready;
    logic       flush_done;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_ready;

    modport master (
        output lead_valid, lead_byte, flush_valid, flush_carry, out_ready,
        input  lead_ready, flush_ready, flush_done, out_valid, out_byte
    );

    modport slave (
        input  lead_valid, lead_byte, flush_valid, flush_carry, out_ready,
        output lead_ready, flush_ready, flush_done, out_valid, out_byte
    );

endinterface

// File: rtl/cabac_out_reg.sv
// Output holding register: keeps out_valid/out_byte stable until the sink
// takes the byte; a new byte may be loaded in the same cycle one is taken.
module cabac_out_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_byte
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
        end else if (load) begin
            out_valid <= 1'b1;
            out_byte  <= load_byte;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cabac_byte_writer.sv
// CABAC byte writer: buffers one byte plus a run of outstanding 0xFF bytes and
// resolves them once the next carry is known (lead byte or end-of-slice flush).
module cabac_byte_writer
    import cabac_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cabac_byte_writer_if.slave   bus,
    output logic [CNT_W-1:0]     num_buf,
    output logic                 ovf_err
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [7:0]       buf_q, buf_d;
    logic             pc_q, pc_d;
    logic             flushing_q, flushing_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             rdy_q, rdy_d;

    logic             load_c;
    logic [7:0]       load_byte_c;
    logic             out_valid_c;
    logic [7:0]       out_byte_c;
    logic             lead_fire_c;
    logic             flush_fire_c;
    logic             out_fire_c;

    // Lead wins over a flush offered in the same cycle.
    assign lead_fire_c  = bus.lead_valid & rdy_q;
    assign flush_fire_c = bus.flush_valid & rdy_q & ~bus.lead_valid;
    assign out_fire_c   = out_valid_c & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            buf_q      <= BUF_INIT;
            pc_q       <= 1'b0;
            flushing_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            buf_q      <= buf_d;
            pc_q       <= pc_d;
            flushing_q <= flushing_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            rdy_q      <= rdy_d;
        end
    end

    // Next state; the first byte is computed at acceptance so it appears next cycle.
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        buf_d       = buf_q;
        pc_d        = pc_q;
        flushing_d  = flushing_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        load_c      = 1'b0;
        load_byte_c = add_carry(BUF_INIT, pc_q);

        case (state_q)
            ST_IDLE: begin
                if (lead_fire_c) begin
                    if (bus.lead_byte == LEAD_OUTSTANDING) begin
                        if (&num_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            num_d = num_q + CNT_W'(1);
                        end
                    end else if (num_q != '0) begin
                        pc_d        = bus.lead_byte.carry;
                        load_c      = 1'b1;
                        load_byte_c = add_carry(buf_q, bus.lead_byte.carry);
                        buf_d       = bus.lead_byte.value;
                        flushing_d  = 1'b0;
                        state_d     = ST_EMIT_FIRST;
                    end else begin
                        buf_d = bus.lead_byte.value;
                        num_d = CNT_W'(1);
                    end
                end else if (flush_fire_c) begin
                    pc_d  = bus.flush_carry;
                    buf_d = BUF_INIT;
                    if (num_q != '0) begin
                        load_c      = 1'b1;
                        load_byte_c = add_carry(buf_q, bus.flush_carry);
                        flushing_d  = 1'b1;
                        state_d     = ST_EMIT_FIRST;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_EMIT_FIRST, ST_EMIT_RUN: begin
                if (out_fire_c) begin
                    if (num_q > CNT_W'(1)) begin
                        num_d   = num_q - CNT_W'(1);
                        load_c  = 1'b1;
                        state_d = ST_EMIT_RUN;
                    end else begin
                        num_d      = flushing_q ? CNT_W'(0) : CNT_W'(1);
                        done_d     = flushing_q;
                        flushing_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rdy_d = (state_d == ST_IDLE);
    end

    cabac_out_reg u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .load_byte (load_byte_c),
        .out_ready (bus.out_ready),
        .out_valid (out_valid_c),
        .out_byte  (out_byte_c)
    );

    assign bus.lead_ready  = rdy_q;
    assign bus.flush_ready = rdy_q & ~bus.lead_valid;
    assign bus.flush_done  = done_q;
    assign bus.out_valid   = out_valid_c;
    assign bus.out_byte    = out_byte_c;
    assign num_buf         = num_q;
    assign ovf_err         = ovf_q;

endmodule
